iir_biquad_cascade: RTL and testbench
=====================================

Name: iir_biquad_cascade

Overview:
- Parametrised cascade of N direct-form-I biquad sections sharing one time-multiplexed multiply-accumulate unit.
- Sits between the audio sample source and the output path, replacing the single-section filter.
- Adds per-section bypass, a double-buffered coefficient bank loaded from the SPI register path, round-to-nearest and output saturation.
- Uses a valid/ready handshake so one sample is processed at a time.

Parameters:
DATA_W, 16, sample width (signed)
COEF_W, 16, coefficient width (signed)
COEF_FRAC, 14, coefficient fractional bits (Q2.14 at defaults)
N_SECTIONS, 4, number of cascaded biquads (1..8)
ACC_W, 36, accumulator width; must be at least DATA_W+COEF_W+3

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  in_sample is valid
in_ready  out  1  block can accept a sample
in_sample  in  DATA_W  x[n], signed
out_valid  out  1  one-cycle pulse, out_sample is valid
out_sample  out  DATA_W  y[n], signed, registered
coef_we  in  1  write one shadow coefficient
coef_sec  in  3  section index for the write
coef_idx  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
coef_data  in  COEF_W  coefficient value
coef_commit  in  1  request copy of the shadow bank to the active bank
bypass_mask  in  N_SECTIONS  bit s set: section s passes its input through
clear_state  in  1  request zeroing of all section histories
sat_flag  out  1  sticky saturation indicator

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - in_ready=1, out_valid=0, out_sample=0, sat_flag=0.
  - All x1/x2/y1/y2 histories are 0.
  - Shadow and active banks are unity: b0=2^COEF_FRAC, all others 0.
  - No commit or clear request is pending.
  - FSM is in IDLE.
- FSM states: IDLE, MAC, WB, OUT.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) captures in_sample as the section-0 input, sets s=0, t=0, clears the accumulator and moves to MAC.
- MAC (5 cycles, t=0..4): acc += b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2 in that order, using active coefficients for section s. Each product is DATA_W+COEF_W bits, sign-extended to ACC_W. Then go to WB.
- WB (1 cycle):
  - r = (acc + 2^(COEF_FRAC−1)) >>> COEF_FRAC (arithmetic shift).
  - Clamp r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. If clamping occurs, set sat_flag.
  - Update section s history: x2←x1, x1←x, y2←y1, y1←clamped r. The clamped result becomes the next section's input.
  - If s<N_SECTIONS−1: increment s, clear acc, go to MAC. Otherwise go to OUT.
- Bypassed section: skips MAC and executes WB with result = input. Its histories are forced to 0 and it cannot saturate.
- OUT (1 cycle): out_sample ← final result, out_valid=1 for exactly this cycle, then return to IDLE.
- Latency: with no bypass, out_valid is high in cycle 6·N_SECTIONS+1 after the handshake edge (25 cycles at defaults). Each bypassed section removes 5 cycles.
- in_ready=0 in every state except IDLE. Back-to-back samples therefore have a throughput of one per latency+1 cycles.
- Coefficient writes:
  - coef_we writes the shadow bank in any state.
  - Writes with coef_sec ≥ N_SECTIONS or coef_idx > 4 are ignored.
  - coef_commit sets a pending flag. The shadow→active copy happens on the first clock in IDLE with no handshake that cycle, so active coefficients never change mid-sample.
  - A coef_we and a coef_commit in the same cycle: the write lands in the shadow bank before the copy.
- clear_state: pending flag, serviced in IDLE like commit. If commit and clear are both pending they are serviced in the same cycle. sat_flag is cleared only by reset_n or by a serviced clear_state.
- bypass_mask is sampled at the handshake and held for the whole sample.
- Reset asserted mid-sample aborts the operation and returns every register to its reset value. No out_valid is produced for the aborted sample.

Decomposition:
- Package iir_pkg holds:
  - FSM state enum.
  - Coefficient index constants (B0..A2).
  - Unity-coefficient constant.
  - Saturation limit helper functions parametrised on DATA_W.
- Sub-module iir_coef_bank holds the shadow and active arrays, write decode and commit copy. It exposes the active coefficient for (section, index) combinationally.

Test Plan:
- Defaults, unity coefficients, no bypass: in_sample=1234 → out_sample=1234 with out_valid 25 cycles after the handshake; in_ready low throughout.
- Section 0 b0=0x2000 (0.5), others unity, committed: 1000 → 500; −1001 → −500, confirming the rounding rule.
- All sections b0=0x7FFF: 20000 → 32767 and sat_flag=1. A following clear_state, once serviced, sets sat_flag=0.
- Section 0 a1=0xE000 (−0.5), b0=1.0: impulse 8192 then zeros → outputs 8192, 4096, 2048, 1024.
- Commit issued mid-sample: the current sample uses the old coefficients and the next sample uses the new ones.
- bypass_mask=4'b1111: out_sample equals in_sample after 5 cycles. reset_n pulsed mid-sample → no out_valid and all outputs at reset values.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and constants for the biquad cascade.
// FSM states, coefficient slots, unity value and saturation limits.
package iir_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_WB,
      S_OUT
   } state_t;

   localparam logic [2:0] C_B0 = 3'd0;
   localparam logic [2:0] C_B1 = 3'd1;
   localparam logic [2:0] C_B2 = 3'd2;
   localparam logic [2:0] C_A1 = 3'd3;
   localparam logic [2:0] C_A2 = 3'd4;
   localparam int N_COEF = 5;

   function automatic longint unity_coef(input int frac);
      return 64'sd1 <<< frac;
   endfunction

   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Double-buffered coefficient store: shadow written any time, active
// copied from shadow on i_commit. Ports: write (i_we/i_wsec/i_widx/
// i_wdata), copy strobe i_commit, combinational read (i_rsec/i_ridx ->
// o_coef) of the active bank.
module iir_coef_bank
   import iir_pkg::*;
#(
   parameter int COEF_W     = 16,
   parameter int COEF_FRAC  = 14,
   parameter int N_SECTIONS = 4,
   parameter int SW         = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_we,
   input  logic [2:0]        i_wsec,
   input  logic [2:0]        i_widx,
   input  logic [COEF_W-1:0] i_wdata,
   input  logic              i_commit,
   input  logic [SW-1:0]     i_rsec,
   input  logic [2:0]        i_ridx,
   output logic [COEF_W-1:0] o_coef
);

   localparam logic [COEF_W-1:0] UNITY =
      COEF_W'(unity_coef(COEF_FRAC));

   logic [COEF_W-1:0] r_shd [N_SECTIONS][N_COEF];
   logic [COEF_W-1:0] r_act [N_SECTIONS][N_COEF];
   logic              w_wr_ok;

   assign w_wr_ok = i_we
                 && (int'(i_wsec) < N_SECTIONS)
                 && (i_widx <= C_A2);

   assign o_coef = r_act[i_rsec][i_ridx];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < N_SECTIONS; s++) begin
            for (int c = 0; c < N_COEF; c++) begin
               r_shd[s][c] <= (c == 0) ? UNITY : '0;
               r_act[s][c] <= (c == 0) ? UNITY : '0;
            end
         end
      end else begin
         if (w_wr_ok)
            r_shd[i_wsec[SW-1:0]][i_widx] <= i_wdata;
         if (i_commit)
            r_act <= r_shd;
      end
   end

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of DF-I biquads sharing one MAC, one sample in flight.
// Ports: sample handshake (in_*/out_*), coefficient path (coef_*),
// bypass_mask, clear_state, sticky sat_flag.
module iir_biquad_cascade
   import iir_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int COEF_W     = 16,
   parameter int COEF_FRAC  = 14,
   parameter int N_SECTIONS = 4,
   parameter int ACC_W      = 36
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_sample,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_sample,
   input  logic                     coef_we,
   input  logic [2:0]               coef_sec,
   input  logic [2:0]               coef_idx,
   input  logic [COEF_W-1:0]        coef_data,
   input  logic                     coef_commit,
   input  logic [N_SECTIONS-1:0]    bypass_mask,
   input  logic                     clear_state,
   output logic                     sat_flag
);

   localparam int SW = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
   localparam int PW = DATA_W + COEF_W;
   localparam logic signed [ACC_W-1:0] HALF =
      ACC_W'(64'sd1 <<< (COEF_FRAC - 1));
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(sat_max(DATA_W));
   localparam logic signed [ACC_W-1:0] MINV = ACC_W'(sat_min(DATA_W));
   localparam logic [SW-1:0] LAST = SW'(N_SECTIONS - 1);

   state_t                    r_state, w_state_nx;
   logic [SW-1:0]             r_sec;
   logic [2:0]                r_t;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [DATA_W-1:0]  r_x;
   logic [N_SECTIONS-1:0]     r_byp;
   logic signed [DATA_W-1:0]  r_x1 [N_SECTIONS];
   logic signed [DATA_W-1:0]  r_x2 [N_SECTIONS];
   logic signed [DATA_W-1:0]  r_y1 [N_SECTIONS];
   logic signed [DATA_W-1:0]  r_y2 [N_SECTIONS];
   logic signed [DATA_W-1:0]  r_out;
   logic                      r_sat, r_cpend, r_clpend;

   logic                      w_hs, w_svc, w_last, w_clamp;
   logic [SW-1:0]             w_sec_nx;
   logic [COEF_W-1:0]         w_coef_raw;
   logic signed [COEF_W-1:0]  w_coef;
   logic signed [DATA_W-1:0]  w_opnd, w_res;
   logic signed [PW-1:0]      w_prod;
   logic signed [ACC_W-1:0]   w_prod_x, w_rnd, w_shf;

   assign w_hs     = in_valid && (r_state == S_IDLE);
   // pending commit/clear only serviced on an idle cycle with no handshake
   assign w_svc    = (r_state == S_IDLE) && !in_valid;
   assign w_last   = (r_sec == LAST);
   assign w_sec_nx = r_sec + SW'(1);

   assign out_sample = r_out;
   assign sat_flag   = r_sat;

   iir_coef_bank #(
      .COEF_W     (COEF_W),
      .COEF_FRAC  (COEF_FRAC),
      .N_SECTIONS (N_SECTIONS),
      .SW         (SW)
   ) u_bank (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_we     (coef_we),
      .i_wsec   (coef_sec),
      .i_widx   (coef_idx),
      .i_wdata  (coef_data),
      .i_commit (w_svc && r_cpend),
      .i_rsec   (r_sec),
      .i_ridx   (r_t),
      .o_coef   (w_coef_raw)
   );

   always_comb begin
      w_opnd = r_x;
      unique case (r_t)
         C_B1:    w_opnd = r_x1[r_sec];
         C_B2:    w_opnd = r_x2[r_sec];
         C_A1:    w_opnd = r_y1[r_sec];
         C_A2:    w_opnd = r_y2[r_sec];
         default: w_opnd = r_x;
      endcase
   end

   assign w_coef   = $signed(w_coef_raw);
   assign w_prod   = w_opnd * w_coef;
   assign w_prod_x = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
   assign w_rnd    = r_acc + HALF;
   assign w_shf    = w_rnd >>> COEF_FRAC;

   always_comb begin
      w_clamp = 1'b0;
      w_res   = w_shf[DATA_W-1:0];
      if (r_byp[r_sec]) begin
         w_res = r_x;
      end else if (w_shf > MAXV) begin
         w_res   = MAXV[DATA_W-1:0];
         w_clamp = 1'b1;
      end else if (w_shf < MINV) begin
         w_res   = MINV[DATA_W-1:0];
         w_clamp = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (w_hs)
               w_state_nx = bypass_mask[0] ? S_WB : S_MAC;
         end
         S_MAC:
            if (r_t == C_A2) w_state_nx = S_WB;
         S_WB:
            if (w_last)              w_state_nx = S_OUT;
            else if (r_byp[w_sec_nx]) w_state_nx = S_WB;
            else                     w_state_nx = S_MAC;
         S_OUT: begin
            out_valid  = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sec    <= '0;
         r_t      <= '0;
         r_acc    <= '0;
         r_x      <= '0;
         r_byp    <= '0;
         r_out    <= '0;
         r_sat    <= 1'b0;
         r_cpend  <= 1'b0;
         r_clpend <= 1'b0;
         for (int s = 0; s < N_SECTIONS; s++) begin
            r_x1[s] <= '0;
            r_x2[s] <= '0;
            r_y1[s] <= '0;
            r_y2[s] <= '0;
         end
      end else begin
         r_cpend  <= (r_cpend && !w_svc) || coef_commit;
         r_clpend <= (r_clpend && !w_svc) || clear_state;
         if (w_svc && r_clpend) begin
            r_sat <= 1'b0;
            for (int s = 0; s < N_SECTIONS; s++) begin
               r_x1[s] <= '0;
               r_x2[s] <= '0;
               r_y1[s] <= '0;
               r_y2[s] <= '0;
            end
         end
         unique case (r_state)
            S_IDLE:
               if (w_hs) begin
                  r_x   <= in_sample;
                  r_sec <= '0;
                  r_t   <= '0;
                  r_acc <= '0;
                  r_byp <= bypass_mask;
               end
            S_MAC: begin
               // feedback terms are subtracted
               if (r_t >= C_A1) r_acc <= r_acc - w_prod_x;
               else             r_acc <= r_acc + w_prod_x;
               if (r_t != C_A2) r_t <= r_t + 3'd1;
            end
            S_WB: begin
               if (r_byp[r_sec]) begin
                  r_x1[r_sec] <= '0;
                  r_x2[r_sec] <= '0;
                  r_y1[r_sec] <= '0;
                  r_y2[r_sec] <= '0;
               end else begin
                  r_x2[r_sec] <= r_x1[r_sec];
                  r_x1[r_sec] <= r_x;
                  r_y2[r_sec] <= r_y1[r_sec];
                  r_y1[r_sec] <= w_res;
               end
               if (w_clamp) r_sat <= 1'b1;
               r_x <= w_res;
               if (w_last) begin
                  r_out <= w_res;
               end else begin
                  r_sec <= w_sec_nx;
                  r_t   <= '0;
                  r_acc <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Self-checking bench for iir_biquad_cascade: fixed vector tables,
// directed multi-cycle sequences and a random run against a model.
module tb_iir_biquad_cascade;

   localparam int DW = 16;
   localparam int CW = 16;
   localparam int CF = 14;
   localparam int NS = 4;
   localparam int AW = 36;

   typedef struct packed {
      logic signed [31:0] x;
      logic signed [31:0] y;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_sample = '0;
   logic                 out_valid;
   logic signed [DW-1:0] out_sample;
   logic                 coef_we = 1'b0;
   logic [2:0]           coef_sec = '0;
   logic [2:0]           coef_idx = '0;
   logic [CW-1:0]        coef_data = '0;
   logic                 coef_commit = 1'b0;
   logic [NS-1:0]        bypass_mask = '0;
   logic                 clear_state = 1'b0;
   logic                 sat_flag;

   int n_run = 0;
   int n_fail = 0;

   int m_act [NS][5];
   int m_shd [NS][5];
   int m_x1 [NS];
   int m_x2 [NS];
   int m_y1 [NS];
   int m_y2 [NS];
   bit m_sat;

   always #5 clk = ~clk;

   iir_biquad_cascade #(
      .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(CF),
      .N_SECTIONS(NS), .ACC_W(AW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sample(in_sample),
      .out_valid(out_valid), .out_sample(out_sample),
      .coef_we(coef_we), .coef_sec(coef_sec),
      .coef_idx(coef_idx), .coef_data(coef_data),
      .coef_commit(coef_commit), .bypass_mask(bypass_mask),
      .clear_state(clear_state), .sat_flag(sat_flag)
   );

   task automatic chk(input string name, input longint act,
                      input longint exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_hist_clear();
      for (int s = 0; s < NS; s++) begin
         m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
      end
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < NS; s++)
         for (int c = 0; c < 5; c++) begin
            m_act[s][c] = (c == 0) ? (1 << CF) : 0;
            m_shd[s][c] = (c == 0) ? (1 << CF) : 0;
         end
      model_hist_clear();
      m_sat = 0;
   endfunction

   // y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, rounded half-up, clamped
   function automatic int model_step(input int x, input logic [NS-1:0] byp);
      int v = x;
      for (int s = 0; s < NS; s++) begin
         longint acc, r;
         if (byp[s]) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
         end else begin
            acc = longint'(m_act[s][0]) * v
                + longint'(m_act[s][1]) * m_x1[s]
                + longint'(m_act[s][2]) * m_x2[s]
                - longint'(m_act[s][3]) * m_y1[s]
                - longint'(m_act[s][4]) * m_y2[s];
            r = (acc + (64'sd1 <<< (CF - 1))) >>> CF;
            if (r > 32767) begin
               r = 32767; m_sat = 1;
            end else if (r < -32768) begin
               r = -32768; m_sat = 1;
            end
            m_x2[s] = m_x1[s]; m_x1[s] = v;
            m_y2[s] = m_y1[s]; m_y1[s] = int'(r);
            v = int'(r);
         end
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; coef_we = 0; coef_commit = 0;
      clear_state = 0; bypass_mask = '0;
      reset_n = 0;
      tick(); tick();
      reset_n = 1;
      tick();
      model_reset();
   endtask

   task automatic wr_coef(input int sec, input int idx, input int val);
      coef_we = 1; coef_sec = 3'(sec); coef_idx = 3'(idx);
      coef_data = 16'(val);
      tick();
      coef_we = 0;
      if (sec < NS && idx <= 4)
         m_shd[sec][idx] = int'($signed(16'(val)));
   endtask

   task automatic commit();
      coef_commit = 1;
      tick();
      coef_commit = 0;
      tick(); tick();
      m_act = m_shd;
   endtask

   task automatic do_clear();
      clear_state = 1;
      tick();
      clear_state = 0;
      tick(); tick();
      model_hist_clear();
      m_sat = 0;
   endtask

   task automatic run_sample(input int x, input bit mid_commit,
                             output int y, output int lat,
                             output bit rdy_ok);
      int w = 0;
      y = 0; lat = -1; rdy_ok = 1;
      while (!in_ready && w < 200) begin
         tick(); w++;
      end
      if (!in_ready) begin
         chk("in_ready_wait", 0, 1);
         return;
      end
      in_valid = 1; in_sample = 16'(x);
      tick();
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_ok = 0;
         coef_commit = mid_commit && (lat == 3);
         tick();
         lat++;
      end
      coef_commit = 0;
      if (!out_valid) begin
         chk("out_valid_timeout", 0, 1);
         lat = -1;
         return;
      end
      if (in_ready) rdy_ok = 0;
      y = int'(out_sample);
      tick();
      chk("out_valid_pulse", out_valid, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [4];
      vec_t imp [4];
      int   y, lat, e, x;
      bit   rok;
      logic [NS-1:0] bm;

      #2 reset_n = 0;
      #10;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sample", out_sample, 0);
      chk("rst_sat_flag", sat_flag, 0);
      do_reset();

      run_sample(1234, 0, y, lat, rok);
      chk("unity_out", y, 1234);
      chk("unity_latency", lat, 25);
      chk("unity_ready_low", rok, 1);

      tbl[0] = '{x: 1000,  y: 500};
      tbl[1] = '{x: -1001, y: -500};
      tbl[2] = '{x: 3,     y: 2};
      tbl[3] = '{x: -3,    y: -1};
      wr_coef(0, 0, 'h2000);
      commit();
      for (int i = 0; i < 4; i++) begin
         run_sample(tbl[i].x, 0, y, lat, rok);
         chk($sformatf("half_tbl%0d", i), y, tbl[i].y);
         chk($sformatf("half_model%0d", i), y,
             model_step(tbl[i].x, '0));
      end

      coef_we = 1; coef_sec = 0; coef_idx = 0; coef_data = 'h1000;
      coef_commit = 1;
      tick();
      coef_we = 0; coef_commit = 0;
      tick(); tick();
      run_sample(1000, 0, y, lat, rok);
      chk("we_commit_same_cycle", y, 250);

      for (int s = 0; s < NS; s++) wr_coef(s, 0, 'h7FFF);
      commit();
      run_sample(20000, 0, y, lat, rok);
      chk("sat_out", y, 32767);
      chk("sat_flag_set", sat_flag, 1);
      do_clear();
      chk("sat_flag_cleared", sat_flag, 0);

      do_reset();
      wr_coef(0, 3, 'hE000);
      commit();
      imp[0] = '{x: 8192, y: 8192};
      imp[1] = '{x: 0,    y: 4096};
      imp[2] = '{x: 0,    y: 2048};
      imp[3] = '{x: 0,    y: 1024};
      for (int i = 0; i < 4; i++) begin
         run_sample(imp[i].x, 0, y, lat, rok);
         chk($sformatf("impulse%0d", i), y, imp[i].y);
      end

      do_reset();
      wr_coef(0, 0, 'h2000);
      run_sample(1000, 1, y, lat, rok);
      chk("midcommit_old", y, 1000);
      tick();
      run_sample(1000, 0, y, lat, rok);
      chk("midcommit_new", y, 500);

      bypass_mask = '1;
      run_sample(-777, 0, y, lat, rok);
      chk("bypass_all_out", y, -777);
      chk("bypass_all_latency", lat, 5);
      bypass_mask = '0;

      do_reset();
      for (int s = 0; s < NS; s++) begin
         wr_coef(s, 0, $urandom_range(0, 32767) - 16384);
         wr_coef(s, 1, $urandom_range(0, 16383) - 8192);
         wr_coef(s, 2, $urandom_range(0, 16383) - 8192);
         wr_coef(s, 3, $urandom_range(0, 16383) - 8192);
         wr_coef(s, 4, $urandom_range(0, 8191) - 4096);
      end
      wr_coef(NS + $urandom_range(0, 7 - NS), 0, 'h1234);
      wr_coef($urandom_range(0, NS - 1), 5 + $urandom_range(0, 2), 'h1234);
      commit();
      for (int i = 0; i < 40; i++) begin
         bm = NS'($urandom_range(0, (1 << NS) - 1));
         x = $urandom_range(0, 65535) - 32768;
         bypass_mask = bm;
         run_sample(x, 0, y, lat, rok);
         e = model_step(x, bm);
         chk($sformatf("rand%0d_out", i), y, e);
         chk($sformatf("rand%0d_lat", i), lat, 6 * NS + 1 - 5 * $countones(bm));
      end
      bypass_mask = '0;
      chk("rand_sat_flag", sat_flag, m_sat);

      in_valid = 1; in_sample = 500;
      tick();
      in_valid = 0;
      for (int i = 0; i < 8; i++) tick();
      reset_n = 0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_sample", out_sample, 0);
      chk("abort_sat_flag", sat_flag, 0);
      tick();
      reset_n = 1;
      model_reset();
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
         end
         chk("abort_no_out_valid", seen, 0);
      end
      run_sample(321, 0, y, lat, rok);
      chk("post_abort_unity", y, 321);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
